// File: rtl/spi_endpoint_router.sv
// Routes one stack send/recv message stream to 2^addr_bits endpoints.
// Responses are merged round-robin; a credit counter bounds in-flight requests.
module spi_endpoint_router #(
  parameter int nbits           = 32,
  parameter int addr_bits       = 2,
  parameter int max_outstanding = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       req_val,
  input  logic [nbits-1:0]                           req_msg,
  output logic                                       req_rdy,
  output logic                                       resp_val,
  output logic [nbits-1:0]                           resp_msg,
  input  logic                                       resp_rdy,
  output logic [(1<<addr_bits)-1:0]                  ep_req_val,
  output logic [nbits-addr_bits-1:0]                 ep_req_msg,
  input  logic [(1<<addr_bits)-1:0]                  ep_req_rdy,
  input  logic [(1<<addr_bits)-1:0]                  ep_resp_val,
  input  logic [(1<<addr_bits)*(nbits-addr_bits)-1:0] ep_resp_msg,
  output logic [(1<<addr_bits)-1:0]                  ep_resp_rdy,
  output logic [7:0]                                 outstanding,
  output logic                                       err
);

  localparam int NumPorts = 1 << addr_bits;
  localparam int PW       = nbits - addr_bits;
  localparam logic [7:0] MaxOut = 8'(max_outstanding);

  logic [addr_bits-1:0] addr_s, idx_s, win_s;
  logic [addr_bits-1:0] rr_q, rr_d;
  logic                 credit_s, found_s, hit_s, grant_s, buf_free_s;
  logic                 req_fire_s, resp_fire_s;
  logic                 resp_val_q, resp_val_d;
  logic [nbits-1:0]     resp_msg_q, resp_msg_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 err_q, err_d;
  int                   base_s;

  // Request decode: zero-latency steering gated by available credit.
  always_comb begin
    addr_s     = req_msg[nbits-1 -: addr_bits];
    credit_s   = (cnt_q < MaxOut);
    req_rdy    = credit_s & ep_req_rdy[addr_s];
    ep_req_msg = req_msg[PW-1:0];
    ep_req_val = '0;
    if (req_val && credit_s) begin
      ep_req_val[addr_s] = 1'b1;
    end else begin
      ep_req_val = '0;
    end
  end

  // Round-robin search starting at the pointer; first valid port wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = rr_q;
    idx_s   = rr_q;
    hit_s   = 1'b0;
    for (int k = 0; k < NumPorts; k++) begin
      idx_s   = rr_q + addr_bits'(k);
      hit_s   = ~found_s & ep_resp_val[idx_s];
      win_s   = hit_s ? idx_s : win_s;
      found_s = found_s | ep_resp_val[idx_s];
    end
    buf_free_s  = ~resp_val_q | resp_rdy;
    grant_s     = found_s & buf_free_s;
    base_s      = int'(win_s) * PW;
    ep_resp_rdy = '0;
    if (grant_s) begin
      ep_resp_rdy[win_s] = 1'b1;
    end else begin
      ep_resp_rdy = '0;
    end
  end

  // Output buffer, pointer and credit counter next-state.
  always_comb begin
    resp_val_d  = resp_val_q;
    resp_msg_d  = resp_msg_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_fire_s  = req_val & req_rdy;
    resp_fire_s = resp_val_q & resp_rdy;
    if (grant_s) begin
      resp_val_d = 1'b1;
      resp_msg_d = {win_s, ep_resp_msg[base_s +: PW]};
      rr_d       = win_s + addr_bits'(1);
    end else if (resp_rdy) begin
      resp_val_d = 1'b0;
    end else begin
      resp_val_d = resp_val_q;
    end
    case ({req_fire_s, resp_fire_s})
      2'b10: cnt_d = cnt_q + 8'd1;
      2'b01: begin
        if (cnt_q == 8'd0) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_val_q <= 1'b0;
      resp_msg_q <= '0;
      rr_q       <= '0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      resp_val_q <= resp_val_d;
      resp_msg_q <= resp_msg_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign resp_val    = resp_val_q;
  assign resp_msg    = resp_msg_q;
  assign outstanding = cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_spi_endpoint_router.sv
// Bench for spi_endpoint_router: directed scenarios plus randomized traffic
// checked against a transaction-level model of credits, arbitration and buffer.
module tb_spi_endpoint_router;

  localparam int NP   = 4;
  localparam int PW   = 30;
  localparam int MAXO = 4;

  logic          clk, reset;
  logic          req_val, req_rdy, resp_val, resp_rdy, err;
  logic [31:0]   req_msg, resp_msg;
  logic [3:0]    ep_req_val, ep_req_rdy, ep_resp_val, ep_resp_rdy;
  logic [PW-1:0] ep_req_msg;
  logic [NP*PW-1:0] ep_resp_msg;
  logic [7:0]    outstanding;
  logic [PW-1:0] s [NP];

  int n_checks, n_pass;
  int m_cnt, m_ptr;
  bit m_rv, m_err;
  logic [31:0] m_rmsg;

  assign ep_resp_msg = {s[3], s[2], s[1], s[0]};

  spi_endpoint_router #(.nbits(32), .addr_bits(2), .max_outstanding(MAXO)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_msg(req_msg), .req_rdy(req_rdy),
    .resp_val(resp_val), .resp_msg(resp_msg), .resp_rdy(resp_rdy),
    .ep_req_val(ep_req_val), .ep_req_msg(ep_req_msg), .ep_req_rdy(ep_req_rdy),
    .ep_resp_val(ep_resp_val), .ep_resp_msg(ep_resp_msg), .ep_resp_rdy(ep_resp_rdy),
    .outstanding(outstanding), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // Advance one clock edge and update the reference model from the inputs seen at it.
  task automatic tick();
    int a, w;
    bit credit, rdy, rf, qf, bfree, found;
    logic [PW-1:0] sl;
    a      = int'(req_msg[31:30]);
    credit = (m_cnt < MAXO);
    rdy    = credit && ep_req_rdy[a];
    rf     = req_val && rdy;
    qf     = m_rv && resp_rdy;
    bfree  = !m_rv || resp_rdy;
    found  = 0;
    w      = 0;
    for (int k = 0; k < NP; k++)
      if (!found && ep_resp_val[(m_ptr + k) % NP]) begin
        found = 1;
        w     = (m_ptr + k) % NP;
      end
    sl = s[w];
    @(posedge clk);
    if (reset) begin
      m_cnt = 0; m_ptr = 0; m_rv = 0; m_err = 0; m_rmsg = '0;
    end else begin
      if (rf && !qf) m_cnt++;
      else if (qf && !rf) begin
        if (m_cnt == 0) m_err = 1;
        else m_cnt--;
      end
      if (found && bfree) begin
        m_rv   = 1;
        m_rmsg = {2'(w), sl};
        m_ptr  = (w + 1) % NP;
      end else if (resp_rdy) m_rv = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_val = 1'b0; req_msg = 32'd0; resp_rdy = 1'b0;
    ep_req_rdy = 4'd0; ep_resp_val = 4'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (resp_val !== 1'b0) $display("FAIL reset_resp_val got %0b exp 0", resp_val); else n_pass++;
    n_checks++; if (resp_msg !== 32'd0) $display("FAIL reset_resp_msg got %h exp 0", resp_msg); else n_pass++;
    n_checks++; if (outstanding !== 8'd0) $display("FAIL reset_outstanding got %0d exp 0", outstanding); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %0b exp 0", err); else n_pass++;
  endtask

  task automatic test_route();
    do_reset();
    ep_req_rdy = 4'hF; req_val = 1'b1; req_msg = 32'h8000_0012;
    #1;
    n_checks++; if (ep_req_val !== 4'b0100) $display("FAIL route_ep_req_val got %b exp 0100", ep_req_val); else n_pass++;
    n_checks++; if (ep_req_msg !== 30'h12) $display("FAIL route_ep_req_msg got %h exp 12", ep_req_msg); else n_pass++;
    n_checks++; if (req_rdy !== 1'b1) $display("FAIL route_req_rdy got %0b exp 1", req_rdy); else n_pass++;
    tick();
    req_val = 1'b0;
    n_checks++; if (outstanding !== 8'd1) $display("FAIL route_outstanding got %0d exp 1", outstanding); else n_pass++;
  endtask

  task automatic test_credit();
    do_reset();
    ep_req_rdy = 4'hF; req_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_msg = {2'd1, 30'($urandom)};
      #1;
      n_checks++; if (req_rdy !== 1'b1) $display("FAIL credit_accept%0d got %0b exp 1", i, req_rdy); else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (req_rdy !== 1'b0) $display("FAIL credit_full_rdy got %0b exp 0", req_rdy); else n_pass++;
    n_checks++; if (ep_req_val !== 4'd0) $display("FAIL credit_full_epval got %b exp 0000", ep_req_val); else n_pass++;
    ep_resp_val = 4'b0010; resp_rdy = 1'b1;
    tick();
    ep_resp_val = 4'd0;
    #1;
    n_checks++; if (req_rdy !== 1'b0) $display("FAIL credit_no_comb_reopen got %0b exp 0", req_rdy); else n_pass++;
    n_checks++; if (resp_msg[31:30] !== 2'd1) $display("FAIL credit_resp_src got %0d exp 1", resp_msg[31:30]); else n_pass++;
    tick();
    n_checks++; if (outstanding !== 8'd3) $display("FAIL credit_after_resp got %0d exp 3", outstanding); else n_pass++;
    n_checks++; if (req_rdy !== 1'b1) $display("FAIL credit_reopen got %0b exp 1", req_rdy); else n_pass++;
    tick();
    req_val = 1'b0;
    n_checks++; if (outstanding !== 8'd4) $display("FAIL credit_refill got %0d exp 4", outstanding); else n_pass++;
  endtask

  task automatic test_rr();
    int p;
    do_reset();
    for (int i = 0; i < NP; i++) s[i] = 30'($urandom);
    ep_resp_val = 4'hF; resp_rdy = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      p = j % NP;
      n_checks++; if (resp_val !== 1'b1) $display("FAIL rr_val%0d got %0b exp 1", j, resp_val); else n_pass++;
      n_checks++; if (resp_msg !== {2'(p), s[p]}) $display("FAIL rr_msg%0d got %h exp %h", j, resp_msg, {2'(p), s[p]}); else n_pass++;
      n_checks++; if (ep_resp_rdy !== 4'(1 << ((j + 1) % NP))) $display("FAIL rr_grant%0d got %b exp %b", j, ep_resp_rdy, 4'(1 << ((j + 1) % NP))); else n_pass++;
      tick();
    end
    ep_resp_val = 4'd0;
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    resp_rdy = 1'b0; ep_resp_val = 4'b1000; s[3] = 30'($urandom);
    tick();
    held = {2'd3, s[3]};
    s[3] = ~s[3];
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (resp_val !== 1'b1) $display("FAIL bp_val%0d got %0b exp 1", i, resp_val); else n_pass++;
      n_checks++; if (resp_msg !== held) $display("FAIL bp_hold%0d got %h exp %h", i, resp_msg, held); else n_pass++;
      n_checks++; if (ep_resp_rdy !== 4'd0) $display("FAIL bp_rdy%0d got %b exp 0000", i, ep_resp_rdy); else n_pass++;
      tick();
    end
    resp_rdy = 1'b1;
    #1;
    n_checks++; if (ep_resp_rdy !== 4'b1000) $display("FAIL bp_release_grant got %b exp 1000", ep_resp_rdy); else n_pass++;
    tick();
    n_checks++; if (resp_msg !== {2'd3, s[3]}) $display("FAIL bp_next_msg got %h exp %h", resp_msg, {2'd3, s[3]}); else n_pass++;
    n_checks++; if (resp_val !== 1'b1) $display("FAIL bp_next_val got %0b exp 1", resp_val); else n_pass++;
    ep_resp_val = 4'd0;
  endtask

  task automatic test_counter_err();
    do_reset();
    ep_req_rdy = 4'hF; req_val = 1'b1; req_msg = {2'd0, 30'($urandom)};
    tick(); tick();
    req_val = 1'b0; ep_resp_val = 4'b0001; resp_rdy = 1'b0;
    tick();
    ep_resp_val = 4'd0; req_val = 1'b1; resp_rdy = 1'b1;
    #1;
    n_checks++; if (req_rdy !== 1'b1) $display("FAIL both_req_rdy got %0b exp 1", req_rdy); else n_pass++;
    tick();
    req_val = 1'b0;
    n_checks++; if (outstanding !== 8'd2) $display("FAIL both_fire_count got %0d exp 2", outstanding); else n_pass++;
    do_reset();
    ep_resp_val = 4'b0001; resp_rdy = 1'b1;
    tick();
    ep_resp_val = 4'd0;
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL underflow_err got %0b exp 1", err); else n_pass++;
    n_checks++; if (outstanding !== 8'd0) $display("FAIL underflow_count got %0d exp 0", outstanding); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %0b exp 1", err); else n_pass++;
    do_reset();
    n_checks++; if (err !== 1'b0) $display("FAIL err_cleared got %0b exp 0", err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    ep_req_rdy = 4'hF; req_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_msg = $urandom;
      tick();
    end
    req_val = 1'b0; ep_resp_val = 4'b0100; resp_rdy = 1'b0;
    tick();
    ep_resp_val = 4'd0;
    n_checks++; if (resp_val !== 1'b1 || outstanding !== 8'd3) $display("FAIL midrst_setup got val=%0b cnt=%0d exp val=1 cnt=3", resp_val, outstanding); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (resp_val !== 1'b0) $display("FAIL midrst_val got %0b exp 0", resp_val); else n_pass++;
    n_checks++; if (outstanding !== 8'd0) $display("FAIL midrst_count got %0d exp 0", outstanding); else n_pass++;
    ep_resp_val = 4'b1010; resp_rdy = 1'b1;
    tick();
    ep_resp_val = 4'd0;
    n_checks++; if (resp_msg[31:30] !== 2'd1) $display("FAIL midrst_ptr got %0d exp 1", resp_msg[31:30]); else n_pass++;
  endtask

  task automatic test_random();
    int a, w;
    bit credit, found, bfree;
    logic [3:0] e_epv, e_eprr;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_val     = 1'($urandom_range(0, 1));
      req_msg     = $urandom;
      ep_req_rdy  = 4'($urandom);
      ep_resp_val = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      for (int i = 0; i < NP; i++) s[i] = 30'($urandom);
      resp_rdy    = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 79) == 0);
      #1;
      a      = int'(req_msg[31:30]);
      credit = (m_cnt < MAXO);
      e_epv  = (req_val && credit) ? 4'(1 << a) : 4'd0;
      bfree  = !m_rv || resp_rdy;
      found  = 0;
      w      = 0;
      for (int k = 0; k < NP; k++)
        if (!found && ep_resp_val[(m_ptr + k) % NP]) begin
          found = 1;
          w     = (m_ptr + k) % NP;
        end
      e_eprr = (found && bfree) ? 4'(1 << w) : 4'd0;
      n_checks++; if (req_rdy !== (credit && ep_req_rdy[a])) $display("FAIL rnd_req_rdy c=%0d got %0b exp %0b", c, req_rdy, credit && ep_req_rdy[a]); else n_pass++;
      n_checks++; if (ep_req_val !== e_epv) $display("FAIL rnd_ep_req_val c=%0d got %b exp %b", c, ep_req_val, e_epv); else n_pass++;
      n_checks++; if (ep_req_msg !== req_msg[29:0]) $display("FAIL rnd_ep_req_msg c=%0d got %h exp %h", c, ep_req_msg, req_msg[29:0]); else n_pass++;
      n_checks++; if (ep_resp_rdy !== e_eprr) $display("FAIL rnd_ep_resp_rdy c=%0d got %b exp %b", c, ep_resp_rdy, e_eprr); else n_pass++;
      n_checks++; if (resp_val !== m_rv) $display("FAIL rnd_resp_val c=%0d got %0b exp %0b", c, resp_val, m_rv); else n_pass++;
      n_checks++; if (resp_msg !== m_rmsg) $display("FAIL rnd_resp_msg c=%0d got %h exp %h", c, resp_msg, m_rmsg); else n_pass++;
      n_checks++; if (outstanding !== 8'(m_cnt)) $display("FAIL rnd_outstanding c=%0d got %0d exp %0d", c, outstanding, m_cnt); else n_pass++;
      n_checks++; if (err !== m_err) $display("FAIL rnd_err c=%0d got %0b exp %0b", c, err, m_err); else n_pass++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    m_cnt = 0; m_ptr = 0; m_rv = 0; m_err = 0; m_rmsg = '0;
    reset = 1'b1; req_val = 1'b0; req_msg = 32'd0; resp_rdy = 1'b0;
    ep_req_rdy = 4'd0; ep_resp_val = 4'd0;
    for (int i = 0; i < NP; i++) s[i] = '0;
    test_reset();
    test_route();
    test_credit();
    test_rr();
    test_backpressure();
    test_counter_err();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
